// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package mult_pkg;
    typedef enum logic [1:0] {IDLE, CALC, FIN, DONE} state_t;

    localparam int FMT_SIGNMAG = 0;
    localparam int FMT_TWOS    = 1;

    // Iteration counter width: ceil(log2(w)), never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction
endpackage

// File: rtl/mag_extract.sv
// Splits an operand into its sign and unsigned WIDTH-bit magnitude.
module mag_extract
    import mult_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int IN_FMT = FMT_SIGNMAG
) (
    input  logic [WIDTH-1:0] x,
    output logic             neg,
    output logic [WIDTH-1:0] mag
);
    assign neg = x[WIDTH-1];

    generate
        if (IN_FMT == FMT_TWOS) begin : g_twos
            // The most negative value maps to 2^(WIDTH-1), still representable unsigned.
            assign mag = neg ? -x : x;
        end else begin : g_signmag
            assign mag = {1'b0, x[WIDTH-2:0]};
        end
    endgenerate
endmodule

// File: rtl/seq_multiplier.sv
// Multi-cycle shift-add multiplier with valid/ready handshakes on both sides.
module seq_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int IN_FMT     = FMT_SIGNMAG,
    parameter int EARLY_TERM = 0
) (
    input  logic               clkin,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a_in,
    input  logic [WIDTH-1:0]   b_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               sign
);
    localparam int CW = cnt_width(WIDTH);
    localparam int PW = 2 * WIDTH;

    state_t            state, state_nxt;
    logic [PW-1:0]     ma, acc, acc_nxt;
    logic [WIDTH-1:0]  mb, mb_sh;
    logic [CW-1:0]     cnt;
    logic              sgn, last;
    logic              neg_a, neg_b;
    logic [WIDTH-1:0]  mag_a, mag_b;

    mag_extract #(.WIDTH(WIDTH), .IN_FMT(IN_FMT)) u_mag_a (.x(a_in), .neg(neg_a), .mag(mag_a));
    mag_extract #(.WIDTH(WIDTH), .IN_FMT(IN_FMT)) u_mag_b (.x(b_in), .neg(neg_b), .mag(mag_b));

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_comb begin
        acc_nxt = mb[0] ? acc + ma : acc;
        mb_sh   = mb >> 1;
        last    = (cnt == CW'(WIDTH - 1)) || ((EARLY_TERM != 0) && (mb_sh == '0));
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_valid)  state_nxt = CALC;
            CALC: if (last)      state_nxt = FIN;
            FIN:                 state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default:             state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            ma      <= '0;
            mb      <= '0;
            acc     <= '0;
            cnt     <= '0;
            sgn     <= 1'b0;
            product <= '0;
            sign    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    ma  <= {{WIDTH{1'b0}}, mag_a};
                    mb  <= mag_b;
                    sgn <= neg_a ^ neg_b;
                    acc <= '0;
                    cnt <= '0;
                end
                CALC: begin
                    acc <= acc_nxt;
                    ma  <= ma << 1;
                    mb  <= mb_sh;
                    cnt <= cnt + CW'(1);
                end
                FIN: begin
                    // A zero magnitude never carries a sign (kills sign-magnitude -0).
                    if (acc == '0) begin
                        product <= '0;
                        sign    <= 1'b0;
                    end else begin
                        product <= sgn ? -acc : acc;
                        sign    <= sgn;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_multiplier.sv
// Randomised and directed checks of seq_multiplier across format / early-exit variants.
module tb_seq_multiplier;
    localparam int W  = 8;
    localparam int NI = 4;  // instance i: IN_FMT = i%2, EARLY_TERM = i/2

    logic clkin = 1'b0;
    logic rst_n;
    logic             iv[NI], ir[NI], ov[NI], ordy[NI], sg[NI];
    logic [W-1:0]     av[NI], bv[NI];
    logic [2*W-1:0]   pr[NI];

    int total = 0;
    int bad   = 0;

    always #5 clkin = ~clkin;

    generate
        for (genvar g = 0; g < NI; g++) begin : g_dut
            seq_multiplier #(.WIDTH(W), .IN_FMT(g % 2), .EARLY_TERM(g / 2)) u_dut (
                .clkin    (clkin),
                .rst_n    (rst_n),
                .in_valid (iv[g]),
                .in_ready (ir[g]),
                .a_in     (av[g]),
                .b_in     (bv[g]),
                .out_valid(ov[g]),
                .out_ready(ordy[g]),
                .product  (pr[g]),
                .sign     (sg[g])
            );
        end
    endgenerate

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] rnd();
        logic [31:0] r;
        r = $urandom;
        return r[W-1:0];
    endfunction

    // Operand value as a plain integer, from the format's definition.
    function automatic longint dec(input int fmt, input logic [W-1:0] x);
        if (fmt == 0) return x[W-1] ? -longint'(x[W-2:0]) : longint'(x[W-2:0]);
        return longint'($signed(x));
    endfunction

    function automatic int exp_c(input int et, input longint bval);
        longint m;
        int n;
        if (et == 0) return W;
        m = (bval < 0) ? -bval : bval;
        n = 0;
        while (m != 0) begin
            n++;
            m = m >> 1;
        end
        return (n < 1) ? 1 : n;
    endfunction

    // One full transaction on instance i, holding the result for 'hold' cycles.
    task automatic txn(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
        longint p;
        logic [2*W-1:0] ep;
        logic es;
        int c, cyc;
        p  = dec(i % 2, a) * dec(i % 2, b);
        ep = p[2*W-1:0];
        es = (p < 0);
        c  = exp_c(i / 2, dec(i % 2, b));
        chk("rdy", 64'(ir[i]), 64'(1));
        av[i] = a; bv[i] = b; iv[i] = 1'b1;
        @(posedge clkin); #1;
        iv[i] = 1'b0; av[i] = rnd(); bv[i] = rnd();
        cyc = 0;
        while (!ov[i] && cyc < 200) begin
            chk("ovl", 64'(ir[i] & ov[i]), 64'(0));
            @(posedge clkin); #1;
            cyc++;
        end
        chk("lat", 64'(cyc), 64'(c + 1));
        chk("prod", 64'(pr[i]), 64'(ep));
        chk("sign", 64'(sg[i]), 64'(es));
        chk("busy", 64'(ir[i]), 64'(0));
        if (hold > 0) begin
            iv[i] = 1'b1;
            repeat (hold) begin
                @(posedge clkin); #1;
                av[i] = rnd(); bv[i] = rnd();
            end
            iv[i] = 1'b0;
            chk("hold_p", 64'(pr[i]), 64'(ep));
            chk("hold_s", 64'(sg[i]), 64'(es));
            chk("hold_v", 64'(ov[i]), 64'(1));
            chk("hold_r", 64'(ir[i]), 64'(0));
        end
        ordy[i] = 1'b1;
        @(posedge clkin); #1;
        ordy[i] = 1'b0;
        chk("ack_v", 64'(ov[i]), 64'(0));
        chk("ack_r", 64'(ir[i]), 64'(1));
    endtask

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < NI; i++) begin
            iv[i] = 1'b0; ordy[i] = 1'b0; av[i] = '0; bv[i] = '0;
        end
        #12;
        for (int i = 0; i < NI; i++) begin
            chk("rst_r", 64'(ir[i]), 64'(1));
            chk("rst_v", 64'(ov[i]), 64'(0));
            chk("rst_p", 64'(pr[i]), 64'(0));
            chk("rst_s", 64'(sg[i]), 64'(0));
        end
        rst_n = 1'b1;
        @(posedge clkin); #1;

        // Directed corners.
        txn(1, 8'h80, 8'h80, 0);   // 0x4000, C=8
        txn(0, 8'h85, 8'h03, 0);   // 0xFFF1
        txn(0, 8'h80, 8'h05, 0);   // -0 * 5 -> 0, sign 0
        txn(3, 8'h7F, 8'h01, 0);   // C=1
        txn(3, 8'h02, 8'h7F, 0);   // C=7
        txn(3, 8'h55, 8'h00, 0);   // zero multiplier, C=1
        txn(2, 8'h83, 8'h07, 20);  // backpressure with input churn

        // Reset during CALC drops the operation.
        txn(1, 8'h03, 8'h05, 0);
        av[1] = 8'h05; bv[1] = 8'h07; iv[1] = 1'b1;
        @(posedge clkin); #1;
        iv[1] = 1'b0;
        repeat (2) @(posedge clkin);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_v", 64'(ov[1]), 64'(0));
        chk("arst_p", 64'(pr[1]), 64'(0));
        chk("arst_s", 64'(sg[1]), 64'(0));
        chk("arst_r", 64'(ir[1]), 64'(1));
        @(posedge clkin); #1;
        rst_n = 1'b1;
        repeat (12) @(posedge clkin);
        #1;
        chk("nores", 64'(ov[1]), 64'(0));
        txn(1, 8'h03, 8'hFD, 0);   // 0xFFF7

        // Random traffic on every variant.
        for (int i = 0; i < NI; i++) begin
            for (int n = 0; n < 30; n++) begin
                logic [W-1:0] a, b;
                a = rnd(); b = rnd();
                if (n % 8 == 0) a = 8'h80;
                if (n % 8 == 1) b = 8'h80;
                if (n % 8 == 2) b = 8'h00;
                txn(i, a, b, int'($urandom_range(0, 2)));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
Parametrised multi-cycle shift-add multiplier for the FFT datapath. Replaces the earlier fixed-format, input-change-triggered multiplier.
- Accepts operands through a valid/ready handshake and supports sign-magnitude or two's-complement inputs.
- Optional early termination.
- Always returns a full-width two's-complement product, held until the consumer accepts it.

Parameters:
WIDTH, 8, operand width in bits including sign bit (>=3)
IN_FMT, 0, operand format: 0 = sign-magnitude (MSB sign), 1 = two's complement
EARLY_TERM, 0, 1 = stop iterating once remaining multiplier magnitude is zero

Ports:
clkin  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands present
in_ready  output  1  block can accept operands (high only in IDLE)
a_in  input  WIDTH  multiplicand
b_in  input  WIDTH  multiplier
out_valid  output  1  product valid
out_ready  input  1  consumer accepts product
product  output  2*WIDTH  signed two's-complement product
sign  output  1  result sign (0 whenever product is 0)

Behaviour:
- Clock and reset: one clock, clkin. Reset rst_n is asynchronous, active-low.
- Reset values:
  - State = IDLE.
  - in_ready=1, out_valid=0, product=0, sign=0.
  - All internal registers = 0.
- Reset mid-operation: the in-flight operation is abandoned and no result is produced. Reset asserted while out_valid=1 drops the result.
- States: IDLE, CALC, FIN, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1, latch the magnitudes |a| and |b| (each WIDTH bits) and the sign sgn = sa^sb.
  - Clear the accumulator (2*WIDTH bits) and the iteration counter (ceil(log2 WIDTH) bits), then go to CALC.
- Operands are sampled only at acceptance. Later changes on a_in/b_in are ignored until the next acceptance.
- Magnitude, IN_FMT=0: low WIDTH-1 bits zero-extended; sign is the MSB.
- Magnitude, IN_FMT=1: the absolute value. -2^(WIDTH-1) gives magnitude 2^(WIDTH-1), which fits in WIDTH bits unsigned.
- CALC, each cycle:
  - If mb[0], acc += ma.
  - ma <<= 1, mb >>= 1, counter++.
  - Exit to FIN after the iteration with counter==WIDTH-1.
  - With EARLY_TERM=1, also exit after any iteration whose shifted mb is 0.
  - CALC cycle count: EARLY_TERM=0 gives exactly WIDTH. EARLY_TERM=1 gives max(1, bit-length of |b|).
- FIN (1 cycle):
  - If acc==0: product=0, sign=0. This suppresses negative zero from sign-magnitude inputs.
  - Otherwise: product = sgn ? -acc : acc, and sign = sgn.
  - Go to DONE.
- DONE:
  - out_valid=1; product and sign are held stable.
  - On an edge with out_ready=1, clear out_valid and go to IDLE.
  - The next operands can be accepted on the following edge, so there is at least one bubble cycle.
- Latency: if operands are accepted at edge k, out_valid is first high after edge k + C + 1, where C is the CALC cycle count.
- Throughput: one result per C + 3 cycles when out_ready is held high.
- Width rule: the maximum magnitude product is 2^(2*WIDTH-2), which is representable in 2*WIDTH signed bits. No overflow is possible and no saturation is performed.
- out_ready while out_valid=0 has no effect. in_valid outside IDLE is ignored and nothing is queued.

Decomposition:
- Package mult_pkg holds:
  - state enum (IDLE, CALC, FIN, DONE);
  - format constants FMT_SIGNMAG=0 and FMT_TWOS=1;
  - a function computing counter width from WIDTH.
- One natural sub-module, mag_extract: parametrised by WIDTH and IN_FMT, it maps an operand to a {sign, WIDTH-bit magnitude} pair. Instantiate it twice, once for a and once for b.
- The FSM and datapath stay in seq_multiplier.

Test Plan:
1. WIDTH=8, IN_FMT=1, EARLY_TERM=0; a=0x80, b=0x80 -> product=0x4000, sign=0; out_valid rises 9 cycles after acceptance.
2. IN_FMT=0; a=0x85 (-5), b=0x03 -> product=0xFFF1, sign=1; a=0x80 (-0), b=0x05 -> product=0x0000, sign=0.
3. IN_FMT=1, EARLY_TERM=1; b=0x01, a=0x7F -> product=0x007F with C=1 (out_valid after 2 cycles); b=0x7F, a=0x02 -> product=0x00FE with C=7; b=0x00 -> product 0 with C=1.
4. Backpressure: hold out_ready=0 for 20 cycles in DONE -> product, sign and out_valid stable, in_ready=0; change a_in/b_in meanwhile -> no effect. Release -> IDLE next edge.
5. Reset: assert rst_n=0 mid-CALC (cycle 3) -> out_valid=0, product=0, in_ready=1 asynchronously. Release and re-issue a=0x03, b=0xFD (IN_FMT=1) -> product=0xFFF7.
6. Randomised back-to-back transactions (all parameter combinations) compared against a reference product; check in_ready never overlaps out_valid.
